mul_arbiter: RTL and testbench

- Shares one radix-2 Booth multiplier datapath (signed WIDTH x WIDTH -> 2*WIDTH) among N_REQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the datapath through load, WIDTH exec steps and done, then returns the product to the granted requester with a one-cycle valid pulse.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// +--------------------------------------------------------------------------+
// | mul_pkg : shared constants and state encoding for the multiplier arbiter |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  localparam int MUL_WIDTH = 64;

  // Datapath command encoding seen on dp_next_state
  localparam logic [1:0] DP_IDLE = 2'b00;
  localparam logic [1:0] DP_EXEC = 2'b01;
  localparam logic [1:0] DP_DONE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_DONE = 3'd3,
    S_RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first set bit from rr_ptr_i |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0] win_idx_o
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;
    sum          = '0;
    pos          = '0;
    valid_o      = 1'b0;
    win_onehot_o = '0;
    win_idx_o    = '0;
    // Walk upward from the pointer, wrapping modulo N_REQ
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!valid_o && req_i[pos]) begin
        valid_o           = 1'b1;
        win_idx_o         = pos;
        win_onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_arbiter.sv
// +--------------------------------------------------------------------------+
// | mul_arbiter : round-robin sharing of one Booth multiplier datapath       |
// | Option      : MUL_ARB_ZERO_BYPASS_EN skips the datapath for 0 operands   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module mul_arbiter
  import mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_multiplier,
  input  logic [N_REQ*WIDTH-1:0]   req_multiplicand,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     busy,
  output logic [1:0]               dp_next_state,
  output logic [CNT_W-1:0]         dp_count,
  output logic [WIDTH-1:0]         dp_multiplier,
  output logic [WIDTH-1:0]         dp_multiplicand,
  input  logic [2*WIDTH-1:0]       dp_result
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    mpl_q, mpl_d;
  logic [WIDTH-1:0]    mcd_q, mcd_d;
  logic                bypass_q, bypass_d;

  logic [WIDTH-1:0]    mpl_arr [N_REQ];
  logic [WIDTH-1:0]    mcd_arr [N_REQ];
  logic                win_valid;
  logic [N_REQ-1:0]    win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                win_zero;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign mpl_arr[i] = req_multiplier[i*WIDTH +: WIDTH];
    assign mcd_arr[i] = req_multiplicand[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req),
    .rr_ptr_i     (ptr_q),
    .valid_o      (win_valid),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx)
  );

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign win_zero = (mpl_arr[win_idx] == '0) || (mcd_arr[win_idx] == '0);
`else
  assign win_zero = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    count_d      = count_q;
    mpl_d        = mpl_q;
    mcd_d        = mcd_q;
    bypass_d     = bypass_q;
    case (state_q)
      S_IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (win_valid) begin
          gnt_d    = win_onehot;
          mpl_d    = mpl_arr[win_idx];
          mcd_d    = mcd_arr[win_idx];
          bypass_d = win_zero;
          ptr_d    = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + IDX_W'(1);
          state_d  = win_zero ? S_RESP : S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        count_d = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        // Result and pulse land together with the return to idle
        rsp_result_d = bypass_q ? '0 : dp_result;
        rsp_valid_d  = gnt_q;
        gnt_d        = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      count_q      <= '0;
      mpl_q        <= '0;
      mcd_q        <= '0;
      bypass_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      count_q      <= count_d;
      mpl_q        <= mpl_d;
      mcd_q        <= mcd_d;
      bypass_q     <= bypass_d;
    end
  end

  always_comb begin
    case (state_q)
      S_EXEC:  dp_next_state = DP_EXEC;
      S_DONE:  dp_next_state = DP_DONE;
      default: dp_next_state = DP_IDLE;
    endcase
  end

  assign gnt             = gnt_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign busy            = (state_q != S_IDLE);
  assign dp_count        = count_q;
  assign dp_multiplier   = mpl_q;
  assign dp_multiplicand = mcd_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mul_arbiter : directed self-checking bench with a cycle-level model   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mul_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 64;
  localparam int CNT_W = 7;
`ifdef MUL_ARB_ZERO_BYPASS_EN
  localparam bit BYP      = 1'b1;
  localparam int LAT_ZERO = 2;
`else
  localparam bit BYP      = 1'b0;
  localparam int LAT_ZERO = 68;
`endif

  logic               clk;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_multiplier;
  logic [N*WIDTH-1:0] req_multiplicand;
  logic [N-1:0]       gnt;
  logic [N-1:0]       rsp_valid;
  logic [2*WIDTH-1:0] rsp_result;
  logic               busy;
  logic [1:0]         dp_next_state;
  logic [CNT_W-1:0]   dp_count;
  logic [WIDTH-1:0]   dp_multiplier;
  logic [WIDTH-1:0]   dp_multiplicand;
  logic [2*WIDTH-1:0] dp_result;

  int n_chk  = 0;
  int n_fail = 0;

  mul_arbiter #(
    .N_REQ (N),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_result       (rsp_result),
    .busy             (busy),
    .dp_next_state    (dp_next_state),
    .dp_count         (dp_count),
    .dp_multiplier    (dp_multiplier),
    .dp_multiplicand  (dp_multiplicand),
    .dp_result        (dp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] smul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] x, y;
    x = {{WIDTH{a[WIDTH-1]}}, a};
    y = {{WIDTH{b[WIDTH-1]}}, b};
    return x * y;
  endfunction

  task automatic chk(input string nm, input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Datapath stand-in: publishes the product only after exactly WIDTH ordered exec steps
  int dp_steps;
  always @(posedge clk) begin
    if (reset) begin
      dp_result <= '0;
      dp_steps  <= 0;
    end else begin
      case (dp_next_state)
        2'b01: dp_steps <= (int'(dp_count) == dp_steps) ? dp_steps + 1 : -1000;
        2'b10: dp_result <= (dp_steps == WIDTH) ? smul(dp_multiplier, dp_multiplicand)
                                                : {2*WIDTH{1'b1}};
        default: begin
          dp_result <= '0;
          dp_steps  <= 0;
        end
      endcase
    end
  end

  // Reference model: m_k counts cycles since the grant edge of the current operation
  bit               m_active, m_byp, chk_en;
  int               m_k, m_lat, m_ptr, m_owner;
  logic [WIDTH-1:0] m_mpl, m_mcd;
  logic [2*WIDTH-1:0] m_res;

  initial begin
    bit found;
    int idx;
    m_active = 0; m_byp = 0; chk_en = 0; m_k = 0; m_lat = WIDTH + 4;
    m_ptr = 0; m_owner = 0; m_mpl = '0; m_mcd = '0; m_res = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 0; m_byp = 0; m_k = 0; m_lat = WIDTH + 4;
        m_ptr = 0; m_owner = 0; m_mpl = '0; m_mcd = '0; m_res = '0;
        chk_en = 1;
      end else begin
        if (m_active && m_k == m_lat) m_active = 0;
        if (!m_active && req != '0) begin
          found = 0;
          for (int j = 0; j < N; j++) begin
            idx = (m_ptr + j) % N;
            if (!found && req[idx]) begin
              found   = 1;
              m_owner = idx;
            end
          end
          m_mpl    = req_multiplier[m_owner*WIDTH +: WIDTH];
          m_mcd    = req_multiplicand[m_owner*WIDTH +: WIDTH];
          m_byp    = BYP && (m_mpl == '0 || m_mcd == '0);
          m_lat    = m_byp ? 2 : WIDTH + 4;
          m_res    = m_byp ? '0 : smul(m_mpl, m_mcd);
          m_ptr    = (m_owner + 1) % N;
          m_active = 1;
          m_k      = 0;
        end
        if (m_active) m_k++;
      end
    end
  end

  initial begin
    logic [N-1:0] oh;
    logic [1:0]   ecmd;
    int           ecnt;
    bit           inop, rsp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        oh   = 4'b1 << m_owner;
        inop = m_active && (m_k < m_lat);
        rsp  = m_active && (m_k == m_lat);
        ecmd = 2'b00;
        ecnt = 0;
        if (inop && !m_byp) begin
          if (m_k >= 2 && m_k <= WIDTH + 1) begin
            ecmd = 2'b01; ecnt = m_k - 2;
          end else if (m_k == WIDTH + 2) begin
            ecmd = 2'b10; ecnt = WIDTH;
          end else if (m_k == WIDTH + 3) begin
            ecnt = -1;
          end
        end else if (inop) begin
          ecnt = -1;
        end
        chk("model gnt", gnt, inop ? oh : 4'b0);
        chk("model busy", busy, inop);
        chk("model rsp_valid", rsp_valid, rsp ? oh : 4'b0);
        if (rsp) chk("model rsp_result", rsp_result, m_res);
        chk("model dp_next_state", dp_next_state, ecmd);
        if (ecnt >= 0) chk("model dp_count", dp_count, ecnt);
        chk("model dp_multiplier", dp_multiplier, m_mpl);
        chk("model dp_multiplicand", dp_multiplicand, m_mcd);
      end
    end
  end

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_multiplier[i*WIDTH +: WIDTH]   = a;
    req_multiplicand[i*WIDTH +: WIDTH] = b;
  endtask

  // Called #2 after a rising edge with the DUT idle
  task automatic do_op(input logic [N-1:0] r, input int exp_w, input logic [2*WIDTH-1:0] exp_res,
                       input int exp_lat, input string nm);
    int ri;
    req = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    chk({nm, " grant"}, gnt, 4'b1 << exp_w);
    @(posedge clk); #2;
    req = '0;
    set_ops(exp_w, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    ri = -10;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ri = i;
        break;
      end
    end
    chk({nm, " latency"}, ri + 1, exp_lat);
    chk({nm, " rsp_valid"}, rsp_valid, 4'b1 << exp_w);
    chk({nm, " rsp_result"}, rsp_result, exp_res);
    @(posedge clk); #2;
  endtask

  int order [5];

  initial begin
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req = '0;
    req_multiplier = '0;
    req_multiplicand = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset gnt", gnt, 4'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_valid", rsp_valid, 4'b0);
    chk("reset rsp_result", rsp_result, 128'd0);
    chk("reset dp_count", dp_count, 7'd0);
    chk("reset dp_next_state", dp_next_state, 2'b00);
    @(posedge clk); #2;

    set_ops(0, 64'd3, 64'd5);
    do_op(4'b0001, 0, 128'd15, 68, "mul3x5");
    set_ops(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6);
    do_op(4'b0010, 1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, 68, "neg7x6");
    set_ops(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    do_op(4'b1000, 3, 128'h4000_0000_0000_0000_0000_0000_0000_0000, 68, "minsq");

    for (int i = 0; i < N; i++) set_ops(i, 64'(i + 2), -64'(i + 10));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (gnt != '0) break;
      end
      chk("rr order", gnt, 4'b1 << order[g]);
      if (g < 4) begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (gnt == '0) break;
        end
        chk("rr gap", rsp_valid, 4'b1 << order[g]);
      end
    end
    @(posedge clk); #2;
    req = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("rr drain", busy, 1'b0);
    @(posedge clk); #2;

    set_ops(2, 64'd11, 64'd13);
    do_op(4'b0100, 2, 128'd143, 68, "wrap r2");
    set_ops(0, 64'd17, 64'd19);
    set_ops(2, 64'd23, 64'd29);
    do_op(4'b0101, 0, 128'd323, 68, "wrap r0");

    set_ops(1, 64'd100, 64'd200);
    req = 4'b0010;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && dp_count == 7'd30) break;
    end
    chk("pre-reset count", dp_count, 7'd30);
    reset = 1'b1;
    req = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset gnt", gnt, 4'b0);
    chk("midreset busy", busy, 1'b0);
    chk("midreset dp_count", dp_count, 7'd0);
    chk("midreset rsp_valid", rsp_valid, 4'b0);
    @(posedge clk); #2;
    set_ops(2, -64'd3, -64'd1000);
    do_op(4'b0100, 2, 128'd3000, 68, "post-reset");

    set_ops(0, 64'd0, 64'd12345);
    do_op(4'b0001, 0, 128'd0, LAT_ZERO, "zero op");

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
